// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the simple CPU bus fabric: transaction FSM states
// and the default boundary between memory (port A) and I/O (port B) space.
package cpu_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } bus_state_e;

   localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_0000;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Cycle counter for an outstanding downstream transaction; flags when the
// next cycle would exhaust the allowed waiting budget.
module bus_timeout_ctr #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] count_r;

   // Count cycles spent in ISSUE/WAIT, restarting at each new acceptance
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         count_r <= {CNT_W{1'b0}};
      end else if (enable) begin
         count_r <= count_r + CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   // High in the last allowed cycle: the counter reaches TIMEOUT at the next edge
   assign expired = (count_r >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_demux_1x2.sv
// One-master, two-slave bus demultiplexer with a single outstanding
// transaction, address-based port select and a downstream response timeout.
module bus_demux_1x2
   import cpu_bus_pkg::*;
#(
   parameter int                  BIT_SIZE = 32,
   parameter logic [BIT_SIZE-1:0] IO_BASE  = BIT_SIZE'(IO_BASE_DEFAULT),
   parameter int                  TIMEOUT  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BIT_SIZE-1:0] in_addr,
   input  logic [BIT_SIZE-1:0] in_wdata,
   input  logic                in_we,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [BIT_SIZE-1:0] rsp_rdata,
   output logic                rsp_err,
   output logic                a_valid,
   input  logic                a_ready,
   output logic [BIT_SIZE-1:0] a_addr,
   output logic [BIT_SIZE-1:0] a_wdata,
   output logic                a_we,
   input  logic                a_rsp_valid,
   input  logic [BIT_SIZE-1:0] a_rdata,
   output logic                b_valid,
   input  logic                b_ready,
   output logic [BIT_SIZE-1:0] b_addr,
   output logic [BIT_SIZE-1:0] b_wdata,
   output logic                b_we,
   input  logic                b_rsp_valid,
   input  logic [BIT_SIZE-1:0] b_rdata
);

   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

   bus_state_e          state_r, state_next_s;
   logic                sel_r, sel_next_s;
   logic [BIT_SIZE-1:0] addr_r, addr_next_s;
   logic [BIT_SIZE-1:0] wdata_r, wdata_next_s;
   logic                we_r, we_next_s;
   logic [BIT_SIZE-1:0] rdata_r, rdata_next_s;
   logic                err_r, err_next_s;
   logic                in_ready_r, a_valid_r, b_valid_r, rsp_valid_r;
   logic                ctr_clear_s, ctr_enable_s, expired_s;
   logic                sel_ready_s, sel_rsp_valid_s;
   logic [BIT_SIZE-1:0] sel_rdata_s;

   // Only the selected port's handshake and data are ever observed
   assign sel_ready_s     = sel_r ? b_ready     : a_ready;
   assign sel_rsp_valid_s = sel_r ? b_rsp_valid : a_rsp_valid;
   assign sel_rdata_s     = sel_r ? b_rdata     : a_rdata;

   assign ctr_enable_s = (state_r == ST_ISSUE) || (state_r == ST_WAIT);

   bus_timeout_ctr #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (ctr_clear_s),
      .enable  (ctr_enable_s),
      .expired (expired_s)
   );

   // Next-state and next-field logic of the transaction FSM
   always_comb begin
      state_next_s = state_r;
      sel_next_s   = sel_r;
      addr_next_s  = addr_r;
      wdata_next_s = wdata_r;
      we_next_s    = we_r;
      rdata_next_s = rdata_r;
      err_next_s   = err_r;
      ctr_clear_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (in_valid) begin
               addr_next_s  = in_addr;
               wdata_next_s = in_wdata;
               we_next_s    = in_we;
               sel_next_s   = (in_addr >= IO_BASE);
               ctr_clear_s  = 1'b1;
               state_next_s = ST_ISSUE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (sel_ready_s) begin
               state_next_s = ST_WAIT;
            end else if (expired_s) begin
               rdata_next_s = {BIT_SIZE{1'b0}};
               err_next_s   = 1'b1;
               state_next_s = ST_RESP;
            end else begin
               state_next_s = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            // Completion is tested first so it wins over a coincident timeout
            if (sel_rsp_valid_s) begin
               rdata_next_s = we_r ? {BIT_SIZE{1'b0}} : sel_rdata_s;
               err_next_s   = 1'b0;
               state_next_s = ST_RESP;
            end else if (expired_s) begin
               rdata_next_s = {BIT_SIZE{1'b0}};
               err_next_s   = 1'b1;
               state_next_s = ST_RESP;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_RESP;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State, latched request/response fields and registered handshake outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         sel_r       <= 1'b0;
         addr_r      <= {BIT_SIZE{1'b0}};
         wdata_r     <= {BIT_SIZE{1'b0}};
         we_r        <= 1'b0;
         rdata_r     <= {BIT_SIZE{1'b0}};
         err_r       <= 1'b0;
         in_ready_r  <= 1'b1;
         a_valid_r   <= 1'b0;
         b_valid_r   <= 1'b0;
         rsp_valid_r <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         sel_r       <= sel_next_s;
         addr_r      <= addr_next_s;
         wdata_r     <= wdata_next_s;
         we_r        <= we_next_s;
         rdata_r     <= rdata_next_s;
         err_r       <= err_next_s;
         in_ready_r  <= (state_next_s == ST_IDLE);
         a_valid_r   <= (state_next_s == ST_ISSUE) && !sel_next_s;
         b_valid_r   <= (state_next_s == ST_ISSUE) && sel_next_s;
         rsp_valid_r <= (state_next_s == ST_RESP);
      end
   end

   assign in_ready  = in_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rdata_r;
   assign rsp_err   = err_r;
   assign a_valid   = a_valid_r;
   assign a_addr    = addr_r;
   assign a_wdata   = wdata_r;
   assign a_we      = we_r;
   assign b_valid   = b_valid_r;
   assign b_addr    = addr_r;
   assign b_wdata   = wdata_r;
   assign b_we      = we_r;

endmodule

// File: tb/tb_bus_demux_1x2.sv
// Directed bench for bus_demux_1x2: expected responses are queued as requests
// are issued and compared when the block presents its upstream response.
module tb_bus_demux_1x2;

   logic        clk;
   logic        reset;
   logic        in_valid, in_ready, in_we;
   logic [31:0] in_addr, in_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        a_valid, a_ready, a_we, a_rsp_valid;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic        b_valid, b_ready, b_we, b_rsp_valid;
   logic [31:0] b_addr, b_wdata, b_rdata;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   k;

   bus_demux_1x2 dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_addr     (in_addr),
      .in_wdata    (in_wdata),
      .in_we       (in_we),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .a_valid     (a_valid),
      .a_ready     (a_ready),
      .a_addr      (a_addr),
      .a_wdata     (a_wdata),
      .a_we        (a_we),
      .a_rsp_valid (a_rsp_valid),
      .a_rdata     (a_rdata),
      .b_valid     (b_valid),
      .b_ready     (b_ready),
      .b_addr      (b_addr),
      .b_wdata     (b_wdata),
      .b_we        (b_we),
      .b_rsp_valid (b_rsp_valid),
      .b_rdata     (b_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic expect_rsp(input logic [31:0] rdata, input logic err);
      exp_t e;
      e.rdata = rdata;
      e.err   = err;
      sb_q.push_back(e);
   endtask

   // Present a request for one cycle; returns just after the accepting edge
   task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic we);
      in_valid = 1'b1;
      in_addr  = addr;
      in_wdata = wdata;
      in_we    = we;
      tick();
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for an upstream response and compare it with the queue head
   task automatic wait_rsp(input string tag);
      exp_t e;
      int   n;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      if (sb_q.size() == 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL %s: observed unexpected response expected none", tag);
      end else begin
         e = sb_q.pop_front();
         check({tag, " rdata"}, rsp_rdata, e.rdata);
         check({tag, " err"}, {31'd0, rsp_err}, {31'd0, e.err});
      end
   endtask

   initial begin
      reset = 1'b1;  in_valid = 1'b0; in_addr = 32'd0; in_wdata = 32'd0; in_we = 1'b0;
      rsp_ready = 1'b1; a_ready = 1'b0; a_rsp_valid = 1'b0; a_rdata = 32'd0;
      b_ready = 1'b0; b_rsp_valid = 1'b0; b_rdata = 32'd0;
      tick();
      tick();
      check("reset in_ready",  {31'd0, in_ready},  32'd1);
      check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset rsp_rdata", rsp_rdata,          32'd0);
      check("reset rsp_err",   {31'd0, rsp_err},   32'd0);
      check("reset a_valid",   {31'd0, a_valid},   32'd0);
      check("reset b_valid",   {31'd0, b_valid},   32'd0);
      check("reset a_addr",    a_addr,             32'd0);
      reset = 1'b0;
      tick();

      // Read on port A
      a_ready = 1'b1;
      issue(32'h0000_0010, 32'd0, 1'b0);
      expect_rsp(32'hDEAD_BEEF, 1'b0);
      check("rdA a_valid",  {31'd0, a_valid},  32'd1);
      check("rdA b_valid",  {31'd0, b_valid},  32'd0);
      check("rdA a_addr",   a_addr,            32'h0000_0010);
      check("rdA in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      check("rdA a_valid one cycle", {31'd0, a_valid}, 32'd0);
      tick();
      a_rsp_valid = 1'b1; a_rdata = 32'hDEAD_BEEF;
      tick();
      a_rsp_valid = 1'b0; a_rdata = 32'd0;
      wait_rsp("rdA");
      tick();
      check("rdA done rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rdA done in_ready",  {31'd0, in_ready},  32'd1);

      // Write on port B; a stray port-A completion must be ignored
      b_ready = 1'b1;
      issue(32'hFFFF_0004, 32'h1234_5678, 1'b1);
      expect_rsp(32'd0, 1'b0);
      check("wrB b_valid", {31'd0, b_valid}, 32'd1);
      check("wrB a_valid", {31'd0, a_valid}, 32'd0);
      check("wrB b_addr",  b_addr,           32'hFFFF_0004);
      check("wrB b_wdata", b_wdata,          32'h1234_5678);
      check("wrB b_we",    {31'd0, b_we},    32'd1);
      tick();
      a_rsp_valid = 1'b1; a_rdata = 32'h1111_1111;
      tick();
      a_rsp_valid = 1'b0;
      check("wrB ignores A rsp", {31'd0, rsp_valid}, 32'd0);
      b_rsp_valid = 1'b1; b_rdata = 32'hCAFE_F00D;
      tick();
      b_rsp_valid = 1'b0;
      wait_rsp("wrB");
      tick();

      // Port B never answers: timeout response TIMEOUT cycles after entering ISSUE
      issue(32'hFFFF_0100, 32'd0, 1'b0);
      expect_rsp(32'd0, 1'b1);
      k = 0;
      while (rsp_valid !== 1'b1 && k < 40) begin
         tick();
         k++;
      end
      check("timeout latency", k, 32'd16);
      wait_rsp("timeout");
      tick();
      b_ready = 1'b0;

      // Port A stalls ready for 5 cycles
      a_ready = 1'b0;
      issue(32'h0000_0020, 32'h0000_AAAA, 1'b0);
      expect_rsp(32'h55AA_55AA, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("stall a_valid",  {31'd0, a_valid},  32'd1);
         check("stall a_addr",   a_addr,            32'h0000_0020);
         check("stall in_ready", {31'd0, in_ready}, 32'd0);
         tick();
      end
      a_ready = 1'b1;
      tick();
      check("stall released a_valid", {31'd0, a_valid}, 32'd0);
      a_rsp_valid = 1'b1; a_rdata = 32'h55AA_55AA;
      tick();
      a_rsp_valid = 1'b0;
      wait_rsp("stall");
      tick();
      check("a_addr held after txn", a_addr, 32'h0000_0020);

      // Completion arriving in the same cycle as the timeout wins
      issue(32'h0000_0060, 32'd0, 1'b0);
      expect_rsp(32'h0BAD_CAFE, 1'b0);
      for (int i = 0; i < 15; i++) tick();
      check("coincide no early rsp", {31'd0, rsp_valid}, 32'd0);
      a_rsp_valid = 1'b1; a_rdata = 32'h0BAD_CAFE;
      tick();
      a_rsp_valid = 1'b0;
      check("coincide rsp at TIMEOUT", {31'd0, rsp_valid}, 32'd1);
      wait_rsp("coincide");
      tick();

      // Upstream back-pressure in RESP with a new request waiting
      issue(32'h0000_0030, 32'd0, 1'b0);
      expect_rsp(32'h7654_3210, 1'b0);
      tick();
      rsp_ready = 1'b0;
      a_rsp_valid = 1'b1; a_rdata = 32'h7654_3210;
      tick();
      a_rsp_valid = 1'b0; a_rdata = 32'h0;
      in_valid = 1'b1; in_addr = 32'h0000_0040; in_we = 1'b0;
      wait_rsp("bp");
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp rsp_valid held", {31'd0, rsp_valid}, 32'd1);
         check("bp rdata held",     rsp_rdata,          32'h7654_3210);
         check("bp in_ready",       {31'd0, in_ready},  32'd0);
         check("bp no issue",       {31'd0, a_valid},   32'd0);
      end
      rsp_ready = 1'b1;
      tick();
      check("bp left RESP rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("bp left RESP in_ready",  {31'd0, in_ready},  32'd1);
      check("bp left RESP a_valid",   {31'd0, a_valid},   32'd0);
      tick();
      in_valid = 1'b0;
      expect_rsp(32'h1357_9BDF, 1'b0);
      check("bp new a_valid", {31'd0, a_valid}, 32'd1);
      check("bp new a_addr",  a_addr,           32'h0000_0040);
      tick();
      a_rsp_valid = 1'b1; a_rdata = 32'h1357_9BDF;
      tick();
      a_rsp_valid = 1'b0;
      wait_rsp("bp2");
      tick();

      // Reset during WAIT drops the transaction; a late completion is ignored
      issue(32'h0000_0050, 32'd0, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midreset in_ready", {31'd0, in_ready}, 32'd1);
      check("midreset a_addr",   a_addr,            32'd0);
      check("midreset a_valid",  {31'd0, a_valid},  32'd0);
      a_rsp_valid = 1'b1; a_rdata = 32'hBAAD_F00D;
      tick();
      a_rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("midreset no rsp", {31'd0, rsp_valid}, 32'd0);
         tick();
      end
      check("scoreboard drained", sb_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
